// File: rtl/soda_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soda_pkg
// Description : Shared widths and FSM state encoding for bcd_2_binary_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package soda_pkg;
    localparam int BIN_W  = 8;
    localparam int BCD_W  = 10;
    localparam int ITER_N = 8;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(ITER_N);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
endpackage
`default_nettype wire

// File: rtl/bcd_2_binary_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_2_binary_seq_if
// Description : Request/result bundle for bcd_2_binary_seq. The err signal
//               exists only when BCD_RANGE_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_2_binary_seq_if;
    import soda_pkg::*;

    logic             start;
    logic [BCD_W-1:0] bcd_in;
    logic             busy;
    logic             done;
    logic [BIN_W-1:0] bin_out;
    logic             ovf;
`ifdef BCD_RANGE_CHECK_EN
    logic             err;

    modport master (output start, bcd_in, input busy, done, bin_out, ovf, err);
    modport slave  (input start, bcd_in, output busy, done, bin_out, ovf, err);
`else
    modport master (output start, bcd_in, input busy, done, bin_out, ovf);
    modport slave  (input start, bcd_in, output busy, done, bin_out, ovf);
`endif
endinterface
`default_nettype wire

// File: rtl/bcd_sub3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_sub3
// Description : Reverse double-dabble digit correction: A>=8 ? A-3 : A.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_sub3 (
    input  wire logic [3:0] i_a,
    output logic      [3:0] o_y
);
    assign o_y = (i_a >= 4'd8) ? (i_a - 4'd3) : i_a;
endmodule
`default_nettype wire

// File: rtl/bcd_2_binary_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_2_binary_seq
// Description : Sequential BCD-to-binary converter (reverse double dabble,
//               one bit per cycle). Define BCD_RANGE_CHECK_EN to add the
//               digit range check and err output.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_2_binary_seq
    import soda_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    bcd_2_binary_seq_if.slave  bus
);
    logic [1:0]        r_state;
    logic [WORK_W-1:0] r_work;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIN_W-1:0]  r_bin_out;
    logic              r_ovf;
    logic [WORK_W-1:0] w_shift;
    logic [WORK_W-1:0] w_next;
    logic [7:0]        w_digits;
    logic              w_last;

    assign w_shift = r_work >> 1;
    assign w_last  = (r_cnt == CNT_W'(ITER_N - 1));

    // Only the tens and units fields are 4 bits wide; the 2-bit hundreds
    // field can never reach 8, so it passes through uncorrected.
    generate
        for (genvar d = 0; d < 2; d++) begin : g_digit
            bcd_sub3 u_sub3 (
                .i_a (w_shift[BIN_W + 4*d +: 4]),
                .o_y (w_digits[4*d +: 4])
            );
        end
    endgenerate

    assign w_next = {w_shift[WORK_W-1 -: 2], w_digits, w_shift[BIN_W-1:0]};

`ifdef BCD_RANGE_CHECK_EN
    logic r_err_pending;
    logic r_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_work    <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
            r_ovf     <= 1'b0;
`ifdef BCD_RANGE_CHECK_EN
            r_err_pending <= 1'b0;
            r_err         <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_work  <= {bus.bcd_in, {BIN_W{1'b0}}};
                        r_cnt   <= '0;
                        r_state <= SHIFT;
`ifdef BCD_RANGE_CHECK_EN
                        r_err_pending <= (bus.bcd_in[7:4] > 4'd9) ||
                                         (bus.bcd_in[3:0] > 4'd9);
`endif
                    end
                end
                SHIFT: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bin_out <= w_next[BIN_W-1:0];
                        // Any residue left in the BCD field means value > 255.
                        r_ovf     <= |w_next[WORK_W-1:BIN_W];
                        r_state   <= DONE;
`ifdef BCD_RANGE_CHECK_EN
                        r_err     <= r_err_pending;
`endif
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.bin_out = r_bin_out;
    assign bus.ovf     = r_ovf;
`ifdef BCD_RANGE_CHECK_EN
    assign bus.err     = r_err;
`endif
endmodule
`default_nettype wire

// File: doc/bcd_2_binary_seq.md
BCD_2_BINARY_SEQ -- requirements
Module: bcd_2_binary_seq

Interface
REQ-001 Parameters: none; widths are fixed by the package constants BIN_W=8 and BCD_W=10.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request a conversion; sampled only in IDLE.
REQ-005 bcd_in  input  10  packed BCD value: [9:8] hundreds (0-3), [7:4] tens, [3:0] units.
REQ-006 busy  output  1  high in SHIFT and DONE; low in IDLE.
REQ-007 done  output  1  one-cycle pulse; bin_out, ovf and err are valid while it is high.
REQ-008 bin_out  output  8  converted binary value; held until the next done.
REQ-009 ovf  output  1  decimal value of bcd_in exceeds 255.
REQ-010 err  output  1  some digit of bcd_in exceeds 9; present only with BCD_RANGE_CHECK_EN.

Function
REQ-011 FSM states: IDLE, SHIFT, DONE.
REQ-012 Transitions: IDLE->SHIFT on start; SHIFT->DONE after 8 iterations; DONE->IDLE unconditionally.
REQ-013 On the edge that samples start in IDLE:
- bcd_in is loaded into an 18-bit work register {bcd[9:0], bin[7:0]}.
- bin is cleared.
- the 3-bit iteration counter is cleared.
REQ-014 Each SHIFT cycle performs one reverse-double-dabble step:
- shift the work register right by 1;
- then, independently per 4-bit digit field of bcd, subtract 3 if the field is >= 8.
REQ-015 Counter and conversion capture:
- the counter increments once per SHIFT cycle;
- on the 8th SHIFT edge (counter==7), the final step result is written to the outputs: bin_out = bin[7:0], ovf = (remaining bcd field != 0).
REQ-016 Latency:
- done is high in the DONE state only, for exactly 1 cycle;
- done rises 8 edges after the edge that samples start;
- back-to-back conversions therefore start at most every 10 cycles.
REQ-017 When ovf=1, bin_out SHALL equal (decimal value mod 256); e.g. 399 gives 0x8F.
REQ-018 start is ignored while busy=1; a start asserted during DONE is not queued.
REQ-019 bcd_in is only sampled at the start edge; changes to it during SHIFT have no effect.
REQ-020 Digit fields > 9 without BCD_RANGE_CHECK_EN: no error detection; bin_out and ovf are whatever the algorithm produces, with no other side effect.

Reset
REQ-021 rst SHALL force state IDLE, busy=0, done=0, bin_out=0, ovf=0, err=0, counter=0 and work register=0.
REQ-022 rst asserted mid-conversion SHALL abort it with no done pulse.
REQ-023 rst has priority over start when both are high on the same edge.

Configuration
REQ-024 Macro BCD_RANGE_CHECK_EN defined:
- the err port exists;
- at the start edge, err_pending is set if bcd_in[7:4] > 9 or bcd_in[3:0] > 9;
- err is driven from err_pending with the same timing as ovf;
- the conversion still runs to DONE.
REQ-025 Macro BCD_RANGE_CHECK_EN undefined: no err port and no checking logic.

Structure
REQ-026 Shared package soda_pkg holds:
- BIN_W=8, BCD_W=10, ITER_N=8;
- the 2-bit state encoding constants IDLE=0, SHIFT=1, DONE=2.
REQ-027 One sub-module bcd_sub3 (4-bit in, 4-bit out: A>=8 ? A-3 : A) SHALL be instantiated once per BCD digit field.

Verification
REQ-028 Test: bcd_in=10'h255 (255) with start pulse -> done at +8 edges, bin_out=8'hFF, ovf=0.
REQ-029 Tests: bcd_in=10'h137 -> bin_out=8'h89, ovf=0; bcd_in=10'h000 -> bin_out=8'h00, ovf=0.
REQ-030 Test: bcd_in=10'h399 -> bin_out=8'h8F, ovf=1; bcd_in=10'h256 -> bin_out=8'h00, ovf=1.
REQ-031 Test: start re-pulsed during SHIFT and DONE, and bcd_in changed mid-conversion -> a single done with the originally sampled result.
REQ-032 Test: rst at iteration 4 -> no done, all outputs 0; a new start afterwards converts correctly.
REQ-033 Test (BCD_RANGE_CHECK_EN): bcd_in=10'h0A5 -> err=1 with done; a following bcd_in=10'h095 -> err=0, bin_out=8'h5F.
